// File: rtl/axi_adapter_arbiter_pkg.sv
// Shared types for the axi_adapter request arbiter.
// Optional feature macro: AXI_ARB_FIXED_PRIO_EN (see axi_adapter_arbiter.sv).
package axi_adapter_arbiter_pkg;

    localparam int unsigned XLEN = 64;

    // Adapter request kind: single beat or full cache line.
    typedef enum logic {
        AD_SINGLE_REQ     = 1'b0,
        AD_CACHE_LINE_REQ = 1'b1
    } ad_req_t;

    // AMO opcode carried alongside the request.
    typedef enum logic [3:0] {
        AMO_NONE = 4'h0,
        AMO_LR   = 4'h1,
        AMO_SC   = 4'h2,
        AMO_SWAP = 4'h3,
        AMO_ADD  = 4'h4,
        AMO_AND  = 4'h5,
        AMO_OR   = 4'h6,
        AMO_XOR  = 4'h7,
        AMO_MAX  = 4'h8,
        AMO_MAXU = 4'h9,
        AMO_MIN  = 4'hA,
        AMO_MINU = 4'hB
    } amo_t;

    // Arbiter ownership FSM.
    typedef enum logic [1:0] {
        ARB_IDLE     = 2'd0,
        ARB_REQ      = 2'd1,
        ARB_WAIT_RSP = 2'd2
    } arb_state_e;

endpackage

// File: rtl/axi_adapter_arbiter_rr_arb_pick.sv
// Combinational pick: first set request at or after ptr_i, wrapping at N-1.
module axi_adapter_arbiter_rr_arb_pick #(
    parameter int unsigned N  = 3,
    parameter int unsigned PW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  onehot_o,
    output logic [PW-1:0] idx_o,
    output logic          valid_o
);

    int unsigned cand;

    // Scan N candidates starting at the pointer; the first hit wins.
    always_comb begin
        onehot_o = '0;
        idx_o    = '0;
        valid_o  = 1'b0;
        cand     = 0;
        for (int unsigned off = 0; off < N; off++) begin
            cand = 32'(ptr_i) + off;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (!valid_o && req_i[PW'(cand)]) begin
                valid_o              = 1'b1;
                idx_o                = PW'(cand);
                onehot_o[PW'(cand)]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axi_adapter_arbiter.sv
// Shares one axi_adapter request port among NUM_PORTS cache-side requesters.
// Ownership is locked from arbitration until the adapter completion pulse.
// Define AXI_ARB_FIXED_PRIO_EN for fixed priority (port 0 highest) instead of round-robin.
module axi_adapter_arbiter
    import axi_adapter_arbiter_pkg::*;
#(
    parameter int unsigned NUM_PORTS      = 3,
    parameter int unsigned DATA_WIDTH     = 256,
    parameter int unsigned AXI_DATA_WIDTH = 64,
    parameter int unsigned AXI_ID_WIDTH   = 4
) (
    input  logic                                                         clk_i,
    input  logic                                                         rst_ni,
    input  logic    [NUM_PORTS-1:0]                                      req_i,
    input  ad_req_t [NUM_PORTS-1:0]                                      type_i,
    input  amo_t    [NUM_PORTS-1:0]                                      amo_i,
    input  logic    [NUM_PORTS-1:0][XLEN-1:0]                            addr_i,
    input  logic    [NUM_PORTS-1:0]                                      we_i,
    input  logic    [NUM_PORTS-1:0][DATA_WIDTH/AXI_DATA_WIDTH-1:0][AXI_DATA_WIDTH-1:0]   wdata_i,
    input  logic    [NUM_PORTS-1:0][DATA_WIDTH/AXI_DATA_WIDTH-1:0][AXI_DATA_WIDTH/8-1:0] be_i,
    input  logic    [NUM_PORTS-1:0][1:0]                                 size_i,
    input  logic    [NUM_PORTS-1:0][AXI_ID_WIDTH-1:0]                    id_i,
    output logic    [NUM_PORTS-1:0]                                      gnt_o,
    output logic    [NUM_PORTS-1:0]                                      valid_o,
    output logic    [DATA_WIDTH/AXI_DATA_WIDTH-1:0][AXI_DATA_WIDTH-1:0]  rdata_o,
    output logic    [NUM_PORTS-1:0]                                      critical_word_valid_o,
    output logic    [AXI_DATA_WIDTH-1:0]                                 critical_word_o,
    output logic                                                         ad_req_o,
    output ad_req_t                                                      ad_type_o,
    output amo_t                                                         ad_amo_o,
    output logic    [XLEN-1:0]                                           ad_addr_o,
    output logic                                                         ad_we_o,
    output logic    [DATA_WIDTH/AXI_DATA_WIDTH-1:0][AXI_DATA_WIDTH-1:0]  ad_wdata_o,
    output logic    [DATA_WIDTH/AXI_DATA_WIDTH-1:0][AXI_DATA_WIDTH/8-1:0] ad_be_o,
    output logic    [1:0]                                                ad_size_o,
    output logic    [AXI_ID_WIDTH-1:0]                                   ad_id_o,
    input  logic                                                         ad_gnt_i,
    input  logic                                                         ad_valid_i,
    input  logic    [DATA_WIDTH/AXI_DATA_WIDTH-1:0][AXI_DATA_WIDTH-1:0]  ad_rdata_i,
    input  logic                                                         ad_cw_valid_i,
    input  logic    [AXI_DATA_WIDTH-1:0]                                 ad_cw_i
);

    localparam int unsigned PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    arb_state_e     state_q, state_d;
    logic [PW-1:0]  owner_q, owner_d;
    logic [PW-1:0]  pick_ptr;
    logic [NUM_PORTS-1:0] pick_onehot;
    logic [PW-1:0]  pick_idx;
    logic           pick_valid;
    logic [PW-1:0]  sel;
    logic           fwd;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] idx);
        return (idx == PW'(NUM_PORTS - 1)) ? '0 : idx + PW'(1);
    endfunction

`ifdef AXI_ARB_FIXED_PRIO_EN
    assign pick_ptr = '0;
`else
    logic [PW-1:0] rr_ptr_q, rr_ptr_d;
    assign pick_ptr = rr_ptr_q;

    // Round-robin pointer register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`endif

    axi_adapter_arbiter_rr_arb_pick #(
        .N  (NUM_PORTS),
        .PW (PW)
    ) u_pick (
        .req_i    (req_i),
        .ptr_i    (pick_ptr),
        .onehot_o (pick_onehot),
        .idx_o    (pick_idx),
        .valid_o  (pick_valid)
    );

    // FSM state and owner registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ARB_IDLE;
            owner_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
        end
    end

    // Next-state, grant routing and response routing.
    always_comb begin
        state_d               = state_q;
        owner_d               = owner_q;
`ifndef AXI_ARB_FIXED_PRIO_EN
        rr_ptr_d              = rr_ptr_q;
`endif
        sel                   = owner_q;
        fwd                   = 1'b0;
        gnt_o                 = '0;
        valid_o               = '0;
        critical_word_valid_o = '0;
        case (state_q)
            ARB_IDLE: begin
                if (pick_valid) begin
                    owner_d = pick_idx;
                    sel     = pick_idx;
                    fwd     = 1'b1;
                    if (ad_gnt_i) begin
                        gnt_o   = pick_onehot;
                        state_d = ARB_WAIT_RSP;
`ifndef AXI_ARB_FIXED_PRIO_EN
                        rr_ptr_d = next_ptr(pick_idx);
`endif
                    end else begin
                        state_d = ARB_REQ;
                    end
                end
            end
            ARB_REQ: begin
                fwd = 1'b1;
                if (ad_gnt_i) begin
                    gnt_o[owner_q] = 1'b1;
                    state_d        = ARB_WAIT_RSP;
`ifndef AXI_ARB_FIXED_PRIO_EN
                    rr_ptr_d = next_ptr(owner_q);
`endif
                end
            end
            ARB_WAIT_RSP: begin
                critical_word_valid_o[owner_q] = ad_cw_valid_i;
                if (ad_valid_i) begin
                    valid_o[owner_q] = 1'b1;
                    state_d          = ARB_IDLE;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
        // Strobes go quiet the moment reset asserts, even with requests pending.
        if (!rst_ni) begin
            fwd                   = 1'b0;
            gnt_o                 = '0;
            valid_o               = '0;
            critical_word_valid_o = '0;
        end
    end

    // Request forward mux; fields are zeroed when no request is presented.
    assign ad_req_o   = fwd;
    assign ad_type_o  = fwd ? type_i[sel] : AD_SINGLE_REQ;
    assign ad_amo_o   = fwd ? amo_i[sel]  : AMO_NONE;
    assign ad_addr_o  = fwd ? addr_i[sel] : '0;
    assign ad_we_o    = fwd ? we_i[sel]   : 1'b0;
    assign ad_wdata_o = fwd ? wdata_i[sel] : '0;
    assign ad_be_o    = fwd ? be_i[sel]   : '0;
    assign ad_size_o  = fwd ? size_i[sel] : '0;
    assign ad_id_o    = fwd ? id_i[sel]   : '0;

    assign rdata_o         = ad_rdata_i;
    assign critical_word_o = ad_cw_i;

    // Requester must hold its request until granted.
    a_req_held: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (state_q == ARB_REQ) |-> req_i[owner_q]);

    // Adapter may only complete while a transaction is outstanding.
    a_valid_in_wait: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (state_q != ARB_WAIT_RSP) |-> !ad_valid_i);

endmodule
